// File: rtl/multicycle_control.sv
// Purpose: Moore control FSM for a multicycle MIPS-style datapath (lw, sw, R-type, beq, j).
// Latency: control outputs decode combinationally from the current state; the state advances on each rising clk.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their state while mem_ready is low.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LOAD_WB  = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t cur_state;
    state_t nxt_state;

    assign state = cur_state;

    // Next-state selection; opcode only matters in DECODE and MEM_ADDR.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:    nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                // An opcode that stopped being a memory op abandons the instruction.
                if (opcode == OP_LW)
                    nxt_state = S_MEM_RD;
                else if (opcode == OP_SW)
                    nxt_state = S_MEM_WR;
                else
                    nxt_state = S_FETCH;
            end
            S_MEM_RD:   nxt_state = mem_ready ? S_LOAD_WB : S_MEM_RD;
            S_LOAD_WB:  nxt_state = S_FETCH;
            S_MEM_WR:   nxt_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     nxt_state = S_R_WB;
            S_R_WB:     nxt_state = S_FETCH;
            S_BRANCH:   nxt_state = S_FETCH;
            S_JUMP:     nxt_state = S_FETCH;
            default:    nxt_state = S_FETCH;
        endcase
    end

    // State register; reset wins over every transition, including memory waits.
    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= S_FETCH;
        else
            cur_state <= nxt_state;
    end

    // Moore output decode; the only mem_ready dependence is the FETCH IR/PC strobe.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (reset) begin
            // Held reset looks like a FETCH that never completes.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
                        default:                              illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_LOAD_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: scoreboard bench for multicycle_control covering lw, sw, R-type, beq, j, illegal and reset cases.
// Latency: expected outputs for a cycle are queued when its inputs are driven and compared at the next falling edge.
// Backpressure: mem_ready is held low to stall FETCH, MEM_WR and MEM_RD.
module tb_multicycle_control;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ILL = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = OP_LW;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected vector {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_op, alu_src_b, pc_source, illegal_op}
    function automatic logic [20:0] model(input int st, input bit mr, input bit rst, input logic [5:0] op);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] aop = 0, asb = 0, psrc = 0;
        if (rst) begin
            mrd = 1; asb = 2'b01;
        end else begin
            case (st)
                0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
                1: begin
                    asb = 2'b11;
                    ill = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_J);
                end
                2: begin asa = 1; asb = 2'b10; end
                3: begin mrd = 1; iod = 1; end
                4: begin rw = 1; m2r = 1; end
                5: begin mwr = 1; iod = 1; end
                6: begin asa = 1; aop = 2'b10; end
                7: begin rw = 1; rdst = 1; end
                8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
                9: begin pw = 1; psrc = 2'b10; end
                default: ;
            endcase
        end
        return {st[3:0], pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, aop, asb, psrc, ill};
    endfunction

    // Drive one cycle of inputs, queue what the DUT must show in that cycle, then advance.
    task automatic step(input bit rst, input bit mr, input logic [5:0] op, input int st, input string tag);
        reset = rst; mem_ready = mr; opcode = op;
        exp_q.push_back(model(st, mr, rst, op));
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    // Drive one cycle without queuing an expectation.
    task automatic drive_only(input bit rst, input bit mr, input logic [5:0] op);
        reset = rst; mem_ready = mr; opcode = op;
        @(posedge clk); #1;
    endtask

    // Compare queued expectations away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {11'd0, state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                      alu_op, alu_src_b, pc_source, illegal_op}, {11'd0, e});
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, OP_LW, 0, "rst_hold_mr1");
        step(1, 0, OP_LW, 0, "rst_hold_mr0");

        step(0, 1, OP_LW, 0, "lw_fetch");
        step(0, 1, OP_LW, 1, "lw_decode");
        step(0, 1, OP_LW, 2, "lw_addr");
        step(0, 1, OP_LW, 3, "lw_memrd");
        step(0, 1, OP_LW, 4, "lw_wb");

        for (int i = 0; i < 3; i++) step(0, 0, OP_R, 0, "r_fetch_stall");
        step(0, 1, OP_R, 0, "r_fetch");
        step(0, 1, OP_R, 1, "r_decode");
        step(0, 1, OP_ILL, 6, "r_exec_opchg");
        step(0, 1, OP_ILL, 7, "r_wb_opchg");

        step(0, 1, OP_SW, 0, "sw_fetch");
        step(0, 1, OP_SW, 1, "sw_decode");
        step(0, 1, OP_SW, 2, "sw_addr");
        step(0, 0, OP_SW, 5, "sw_wr_stall1");
        step(0, 0, OP_SW, 5, "sw_wr_stall2");
        step(0, 1, OP_SW, 5, "sw_wr_done");

        step(0, 1, OP_BEQ, 0, "beq_fetch");
        step(0, 1, OP_BEQ, 1, "beq_decode");
        step(0, 1, OP_BEQ, 8, "beq_branch");

        step(0, 1, OP_J, 0, "j_fetch");
        step(0, 1, OP_J, 1, "j_decode");
        step(0, 1, OP_J, 9, "j_jump");

        step(0, 1, OP_ILL, 0, "ill_fetch");
        step(0, 1, OP_ILL, 1, "ill_decode");

        step(0, 1, OP_LW, 0, "after_ill_fetch");
        step(0, 1, OP_LW, 1, "rm_decode");
        step(0, 1, OP_LW, 2, "rm_addr");
        step(0, 0, OP_LW, 3, "rm_memrd_stall1");
        step(0, 0, OP_LW, 3, "rm_memrd_stall2");
        drive_only(1, 0, OP_LW);
        step(1, 0, OP_LW, 0, "rm_reset_hold");
        step(0, 0, OP_LW, 0, "rm_after_reset");
        step(0, 1, OP_LW, 0, "rm_refetch");
        step(0, 1, OP_LW, 1, "rm_redecode");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs: opcode  in  6  instruction bits [31:26] from IR; mem_ready  in  1  memory access completes this cycle.
REQ-003 The block SHALL have these datapath control outputs, each 1 bit: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-004 The block SHALL have these multi-bit outputs: alu_op  out  2  to alu_control (00 add, 01 sub, 10 use funct); alu_src_b  out  2; pc_source  out  2; state  out  4  current state code.
REQ-005 The block SHALL have this status output: illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-006 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LOAD_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, and the state register SHALL update only on rising clk.
REQ-007 Outputs SHALL be combinational from state, plus mem_ready where noted; every output not listed for a state SHALL be 0.
REQ-008 FETCH SHALL drive mem_read=1, alu_src_b=01, alu_op=00, and SHALL drive ir_write=1 and pc_write=1 only when mem_ready=1.
REQ-009 FETCH SHALL stay in FETCH while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-010 DECODE SHALL drive alu_src_b=11 and alu_op=00.
REQ-011 DECODE SHALL select the next state from opcode: 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP.
REQ-012 DECODE SHALL treat any other opcode as illegal: next state FETCH, with illegal_op=1 during that DECODE cycle only.
REQ-013 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, and SHALL go to MEM_RD for lw and MEM_WR for sw.
REQ-014 MEM_RD SHALL drive mem_read=1 and i_or_d=1, SHALL hold while mem_ready=0, and SHALL go to LOAD_WB when mem_ready=1.
REQ-015 LOAD_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-016 MEM_WR SHALL drive mem_write=1 and i_or_d=1, SHALL hold while mem_ready=0, and SHALL go to FETCH when mem_ready=1.
REQ-017 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
REQ-018 R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-020 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-021 Opcode SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.
REQ-022 Unused state codes 10-15 SHALL drive all outputs to 0 and SHALL go to FETCH on the next clk.
REQ-023 Instruction cycle counts with mem_ready held at 1 SHALL be: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.

Reset
REQ-024 reset=1 at a rising clk SHALL force state=FETCH (0000) regardless of current state, including during a memory wait.
REQ-025 reset SHALL take priority over every transition.
REQ-026 While reset is held, outputs SHALL equal FETCH values with ir_write=0 and pc_write=0, regardless of mem_ready.
REQ-027 Immediately after reset, outputs SHALL equal FETCH values: mem_read=1, alu_src_b=01, alu_op=00, all others 0.

Verification
REQ-028 Test lw: reset, mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-029 Test R-type with stall: opcode=000000, mem_ready=0 for 3 cycles in FETCH -> state held 0 for 3 cycles with ir_write=0, then 1,6,7,0; alu_op=10 in state 6.
REQ-030 Test sw with stall: opcode=101011, mem_ready=0 for 2 cycles in MEM_WR -> states 0,1,2,5,5,5,0; mem_write=1 for all three state-5 cycles.
REQ-031 Test beq and j: beq -> 0,1,8,0 with alu_op=01 and pc_write_cond=1 in state 8; j -> 0,1,9,0 with pc_source=10 and pc_write=1 in state 9.
REQ-032 Test illegal opcode: opcode=111111 -> 0,1,0 with illegal_op=1 for exactly one cycle (in state 1).
REQ-033 Test reset mid-operation: reset=1 asserted in MEM_RD while mem_ready=0 -> state=0 on the next clk, and no reg_write pulse occurs.
